// File: rtl/rv_mem_stage_hs_pkg.sv
// Shared encodings for the handshaked MEM stage: writeback-value selects,
// access-size codes (funct3[1:0]) and the dmem handshake FSM states.
package rv_mem_stage_hs_pkg;

  localparam logic [1:0] SRC_RF_WD_ALU       = 2'd0;
  localparam logic [1:0] SRC_RF_WD_IMMEXT    = 2'd1;
  localparam logic [1:0] SRC_RF_WD_PC_PLUS_4 = 2'd2;

  // funct3[1:0] is the access size, funct3[2] selects zero extension
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } mem_state_e;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] addr);
    case (f3[1:0])
      SZ_H:    return addr[0];
      SZ_W:    return |addr[1:0];
      SZ_D:    return |addr[2:0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_mem_lane_align.sv
// Byte-lane steering for the dmem bus: store replicate/rotate with strobes,
// load rotate-down and sign/zero extension. Purely combinational.
module rv_mem_lane_align
  import rv_mem_stage_hs_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NBYTES = XLEN / 8,
  localparam int OFFW = $clog2(NBYTES)
) (
  input  logic [1:0]        i_st_size,
  input  logic [OFFW-1:0]   i_st_off,
  input  logic [XLEN-1:0]   i_st_data,
  output logic [NBYTES-1:0] o_wstrb,
  output logic [XLEN-1:0]   o_wdata,
  input  logic [2:0]        i_ld_f3,
  input  logic [OFFW-1:0]   i_ld_off,
  input  logic [XLEN-1:0]   i_ld_data,
  output logic [XLEN-1:0]   o_ld_data
);

  logic [XLEN-1:0]        rep;
  logic [NBYTES-1:0]      mask;
  logic [XLEN-1:0]        ld_rot;
  logic [XLEN-1:0]        ld_top;
  logic signed [XLEN-1:0] ld_top_s;
  int                     st_sh;
  int                     ld_sh;
  int                     ext_sh;

  always_comb begin
    rep  = i_st_data;
    mask = '1;
    case (i_st_size)
      SZ_B: begin rep = {NBYTES{i_st_data[7:0]}};        mask = NBYTES'(1);  end
      SZ_H: begin rep = {(NBYTES/2){i_st_data[15:0]}};   mask = NBYTES'(3);  end
      SZ_W: begin rep = {(NBYTES/4){i_st_data[31:0]}};   mask = NBYTES'(15); end
      default: ;
    endcase
    // Rotations keep misaligned items wrapping inside the bus word
    st_sh   = 8 * int'(i_st_off);
    o_wdata = (rep << st_sh) | (rep >> (XLEN - st_sh));
    o_wstrb = (mask << i_st_off) | (mask >> (NBYTES - int'(i_st_off)));
  end

  always_comb begin
    ld_sh  = 8 * int'(i_ld_off);
    ld_rot = (i_ld_data >> ld_sh) | (i_ld_data << (XLEN - ld_sh));
    case (i_ld_f3[1:0])
      SZ_B:    ext_sh = XLEN - 8;
      SZ_H:    ext_sh = XLEN - 16;
      SZ_W:    ext_sh = XLEN - 32;
      default: ext_sh = 0;
    endcase
    // Park the item at the top, then shift back down to extend it
    ld_top   = ld_rot << ext_sh;
    ld_top_s = ld_top;
    o_ld_data = '0;
    if (i_ld_f3[2]) o_ld_data = ld_top >> ext_sh;
    else            o_ld_data = ld_top_s >>> ext_sh;
  end

endmodule

// File: rtl/rv_mem_stage_hs.sv
// RV32I/RV64I MEM stage with a req/gnt + rvalid data-memory port.
// Optional macro RV_MEM_MISALIGN_TRAP_EN traps misaligned H/W/D accesses.
module rv_mem_stage_hs
  import rv_mem_stage_hs_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NBYTES = XLEN / 8
) (
  input  logic              i_mem_clk,
  input  logic              i_mem_rstn,
  input  logic              i_mem_valid,
  input  logic              i_mem_is_load,
  input  logic              i_mem_dmem_we,
  input  logic [XLEN-1:0]   i_mem_alu_res,
  input  logic [XLEN-1:0]   i_mem_immext_res,
  input  logic [XLEN-1:0]   i_mem_pc_plus_4,
  input  logic [XLEN-1:0]   i_mem_dmem_wd,
  input  logic [2:0]        i_mem_dmem_bytectrl,
  input  logic              i_mem_rf_we,
  input  logic [4:0]        i_mem_rf_wa,
  input  logic [1:0]        i_mem_rf_wd_pre_sel,
  output logic              o_mem_stall,
  output logic [XLEN-1:0]   o_mem_rf_rd_fwd,
  output logic              o_mem_wb_valid,
  output logic              o_mem_wb_is_load,
  output logic              o_mem_wb_rf_we,
  output logic [4:0]        o_mem_wb_rf_wa,
  output logic [XLEN-1:0]   o_mem_wb_dmem_rd,
  output logic [XLEN-1:0]   o_mem_wb_rf_wd_pre,
`ifdef RV_MEM_MISALIGN_TRAP_EN
  output logic              o_mem_misalign,
`endif
  output logic              o_dmem_req,
  input  logic              i_dmem_gnt,
  output logic [XLEN-1:0]   o_dmem_addr,
  output logic              o_dmem_we,
  output logic [NBYTES-1:0] o_dmem_wstrb,
  output logic [XLEN-1:0]   o_dmem_wdata,
  input  logic              i_dmem_rvalid,
  input  logic [XLEN-1:0]   i_dmem_rdata
);

  localparam int OFFW = $clog2(NBYTES);

  mem_state_e      state_q, state_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic            wb_valid_q, wb_valid_d;
  logic            wb_is_load_q, wb_is_load_d;
  logic            wb_rf_we_q, wb_rf_we_d;
  logic            misal_q, misal_d;
  logic [4:0]      wb_rf_wa_q, wb_rf_wa_d;
  logic [XLEN-1:0] wb_dmem_rd_q, wb_dmem_rd_d;
  logic [XLEN-1:0] wb_rf_wd_pre_q, wb_rf_wd_pre_d;

  logic            mem_op, misal, issue, gnt_acc, cpl;
  logic [XLEN-1:0] fwd, ld_ext;

  assign mem_op = i_mem_valid & (i_mem_is_load | i_mem_dmem_we);
`ifdef RV_MEM_MISALIGN_TRAP_EN
  assign misal  = mem_op & is_misaligned(i_mem_dmem_bytectrl, i_mem_alu_res[2:0]);
`else
  assign misal  = 1'b0;
`endif
  assign issue  = mem_op & ~misal;

  // Request and stall are killed by reset so an aborted access vanishes at once
  assign o_dmem_req  = i_mem_rstn & ((state_q == ST_REQ) | ((state_q == ST_IDLE) & issue));
  assign gnt_acc     = o_dmem_req & i_dmem_gnt;
  assign cpl         = i_mem_valid & (~mem_op | misal | (~i_mem_is_load & gnt_acc) |
                       (i_mem_is_load & (state_q == ST_RSP) & i_dmem_rvalid));
  assign o_mem_stall = i_mem_rstn & mem_op & ~cpl;

  assign o_dmem_addr = i_mem_alu_res;
  assign o_dmem_we   = i_mem_dmem_we & ~i_mem_is_load;

  always_comb begin
    case (i_mem_rf_wd_pre_sel)
      SRC_RF_WD_IMMEXT:    fwd = i_mem_immext_res;
      SRC_RF_WD_PC_PLUS_4: fwd = i_mem_pc_plus_4;
      default:             fwd = i_mem_alu_res;
    endcase
  end
  assign o_mem_rf_rd_fwd = fwd;

  rv_mem_lane_align #(.XLEN(XLEN)) u_lane (
    .i_st_size (i_mem_dmem_bytectrl[1:0]),
    .i_st_off  (i_mem_alu_res[OFFW-1:0]),
    .i_st_data (i_mem_dmem_wd),
    .o_wstrb   (o_dmem_wstrb),
    .o_wdata   (o_dmem_wdata),
    .i_ld_f3   (f3_q),
    .i_ld_off  (off_q),
    .i_ld_data (i_dmem_rdata),
    .o_ld_data (ld_ext)
  );

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    f3_d    = f3_q;
    // Offset and size are captured at grant for the later rvalid extraction
    if (gnt_acc & i_mem_is_load) begin
      off_d = i_mem_alu_res[OFFW-1:0];
      f3_d  = i_mem_dmem_bytectrl;
    end
    case (state_q)
      ST_IDLE: if (issue) state_d = gnt_acc ? (i_mem_is_load ? ST_RSP : ST_IDLE) : ST_REQ;
      ST_REQ:  if (gnt_acc) state_d = i_mem_is_load ? ST_RSP : ST_IDLE;
      ST_RSP:  if (i_dmem_rvalid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_valid_d     = cpl;
    wb_is_load_d   = cpl & i_mem_is_load;
    wb_rf_we_d     = cpl & i_mem_rf_we & ~misal;
    misal_d        = cpl & misal;
    wb_rf_wa_d     = wb_rf_wa_q;
    wb_dmem_rd_d   = wb_dmem_rd_q;
    wb_rf_wd_pre_d = wb_rf_wd_pre_q;
    if (cpl) begin
      wb_rf_wa_d     = i_mem_rf_wa;
      wb_dmem_rd_d   = ld_ext;
      wb_rf_wd_pre_d = fwd;
    end
  end

  always_ff @(posedge i_mem_clk or negedge i_mem_rstn) begin
    if (!i_mem_rstn) begin
      state_q        <= ST_IDLE;
      off_q          <= '0;
      f3_q           <= '0;
      wb_valid_q     <= 1'b0;
      wb_is_load_q   <= 1'b0;
      wb_rf_we_q     <= 1'b0;
      misal_q        <= 1'b0;
      wb_rf_wa_q     <= '0;
      wb_dmem_rd_q   <= '0;
      wb_rf_wd_pre_q <= '0;
    end else begin
      state_q        <= state_d;
      off_q          <= off_d;
      f3_q           <= f3_d;
      wb_valid_q     <= wb_valid_d;
      wb_is_load_q   <= wb_is_load_d;
      wb_rf_we_q     <= wb_rf_we_d;
      misal_q        <= misal_d;
      wb_rf_wa_q     <= wb_rf_wa_d;
      wb_dmem_rd_q   <= wb_dmem_rd_d;
      wb_rf_wd_pre_q <= wb_rf_wd_pre_d;
    end
  end

  assign o_mem_wb_valid     = wb_valid_q;
  assign o_mem_wb_is_load   = wb_is_load_q;
  assign o_mem_wb_rf_we     = wb_rf_we_q;
  assign o_mem_wb_rf_wa     = wb_rf_wa_q;
  assign o_mem_wb_dmem_rd   = wb_dmem_rd_q;
  assign o_mem_wb_rf_wd_pre = wb_rf_wd_pre_q;
`ifdef RV_MEM_MISALIGN_TRAP_EN
  assign o_mem_misalign     = misal_q;
`else
  logic unused_misal;
  assign unused_misal = misal_q;
`endif

endmodule

// File: tb/tb_rv_mem_stage_hs.sv
// Bench for rv_mem_stage_hs: 32-bit and 64-bit instances, vector table for
// single-cycle ops plus handshake sequences, writeback checked by scoreboard.
module tb_rv_mem_stage_hs;
  import rv_mem_stage_hs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, v32, v64, is_load, dwe, rf_we, gnt, rvalid;
  logic [2:0]  f3;
  logic [4:0]  wa;
  logic [1:0]  sel;
  logic [63:0] alu, imm, pc4, wd, rdata;

  logic        stall32, req32, we32, wbv32, wbl32, wbwe32, misal32;
  logic [4:0]  wbwa32;
  logic [31:0] fwd32, wbrd32, wbpre32, addr32, wdata32;
  logic [3:0]  strb32;
  logic        stall64, req64, we64, wbv64, wbl64, wbwe64, misal64;
  logic [4:0]  wbwa64;
  logic [63:0] fwd64, wbrd64, wbpre64, addr64, wdata64;
  logic [7:0]  strb64;

  rv_mem_stage_hs #(.XLEN(32)) u32 (
    .i_mem_clk(clk), .i_mem_rstn(rstn), .i_mem_valid(v32), .i_mem_is_load(is_load),
    .i_mem_dmem_we(dwe), .i_mem_alu_res(alu[31:0]), .i_mem_immext_res(imm[31:0]),
    .i_mem_pc_plus_4(pc4[31:0]), .i_mem_dmem_wd(wd[31:0]), .i_mem_dmem_bytectrl(f3),
    .i_mem_rf_we(rf_we), .i_mem_rf_wa(wa), .i_mem_rf_wd_pre_sel(sel),
    .o_mem_stall(stall32), .o_mem_rf_rd_fwd(fwd32), .o_mem_wb_valid(wbv32),
    .o_mem_wb_is_load(wbl32), .o_mem_wb_rf_we(wbwe32), .o_mem_wb_rf_wa(wbwa32),
    .o_mem_wb_dmem_rd(wbrd32), .o_mem_wb_rf_wd_pre(wbpre32),
`ifdef RV_MEM_MISALIGN_TRAP_EN
    .o_mem_misalign(misal32),
`endif
    .o_dmem_req(req32), .i_dmem_gnt(gnt), .o_dmem_addr(addr32), .o_dmem_we(we32),
    .o_dmem_wstrb(strb32), .o_dmem_wdata(wdata32), .i_dmem_rvalid(rvalid),
    .i_dmem_rdata(rdata[31:0])
  );

  rv_mem_stage_hs #(.XLEN(64)) u64 (
    .i_mem_clk(clk), .i_mem_rstn(rstn), .i_mem_valid(v64), .i_mem_is_load(is_load),
    .i_mem_dmem_we(dwe), .i_mem_alu_res(alu), .i_mem_immext_res(imm),
    .i_mem_pc_plus_4(pc4), .i_mem_dmem_wd(wd), .i_mem_dmem_bytectrl(f3),
    .i_mem_rf_we(rf_we), .i_mem_rf_wa(wa), .i_mem_rf_wd_pre_sel(sel),
    .o_mem_stall(stall64), .o_mem_rf_rd_fwd(fwd64), .o_mem_wb_valid(wbv64),
    .o_mem_wb_is_load(wbl64), .o_mem_wb_rf_we(wbwe64), .o_mem_wb_rf_wa(wbwa64),
    .o_mem_wb_dmem_rd(wbrd64), .o_mem_wb_rf_wd_pre(wbpre64),
`ifdef RV_MEM_MISALIGN_TRAP_EN
    .o_mem_misalign(misal64),
`endif
    .o_dmem_req(req64), .i_dmem_gnt(gnt), .o_dmem_addr(addr64), .o_dmem_we(we64),
    .o_dmem_wstrb(strb64), .o_dmem_wdata(wdata64), .i_dmem_rvalid(rvalid),
    .i_dmem_rdata(rdata)
  );

`ifndef RV_MEM_MISALIGN_TRAP_EN
  assign misal32 = 1'b0;
  assign misal64 = 1'b0;
`endif

  typedef struct {
    logic [4:0]  wa;
    logic        rf_we;
    logic        is_load;
    logic        chk_rd;
    logic [63:0] pre;
    logic [63:0] rd;
  } wb_exp_t;

  typedef struct {
    logic        vld, ld, we;
    logic [2:0]  f3;
    logic [1:0]  sel;
    logic        rfwe;
    logic [4:0]  wa;
    logic        g;
    logic [63:0] alu, imm, pc4, wd, fwd;
    logic        stall, req;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } vec_t;

  wb_exp_t q32[$];
  wb_exp_t q64[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin : mon
    wb_exp_t e;
    #1;
    if (wbv32 === 1'b1) begin
      if (q32.size() == 0) chk("wb32_unexpected_valid", wbv32, 0);
      else begin
        e = q32.pop_front();
        chk("wb32_rf_wa", wbwa32, e.wa);
        chk("wb32_rf_we", wbwe32, e.rf_we);
        chk("wb32_is_load", wbl32, e.is_load);
        chk("wb32_rf_wd_pre", wbpre32, e.pre);
        if (e.chk_rd) chk("wb32_dmem_rd", wbrd32, e.rd);
      end
    end
    if (wbv64 === 1'b1) begin
      if (q64.size() == 0) chk("wb64_unexpected_valid", wbv64, 0);
      else begin
        e = q64.pop_front();
        chk("wb64_rf_wa", wbwa64, e.wa);
        chk("wb64_rf_we", wbwe64, e.rf_we);
        chk("wb64_is_load", wbl64, e.is_load);
        chk("wb64_rf_wd_pre", wbpre64, e.pre);
        if (e.chk_rd) chk("wb64_dmem_rd", wbrd64, e.rd);
      end
    end
  end

  // One memory access with grant after gd cycles and rvalid rd cycles after grant
  task automatic mem_seq(input string nm, input bit b64, input bit ld, input logic [2:0] fn,
                         input logic [63:0] addr, input logic [63:0] wdat, input logic [63:0] rdat,
                         input int gd, input int rd, input logic [63:0] exp_rd,
                         input logic [7:0] exp_strb, input logic [63:0] exp_wdata,
                         input int exp_stalls);
    int      stalls;
    bit      done;
    logic    st;
    wb_exp_t e;
    stalls = 0;
    done   = 0;
    @(negedge clk);
    v32 = !b64; v64 = b64; is_load = ld; dwe = !ld; f3 = fn; alu = addr; wd = wdat;
    rdata = rdat; rf_we = ld; wa = 5'd7; sel = SRC_RF_WD_ALU;
    for (int c = 0; c < 20 && !done; c++) begin
      if (c > 0) @(negedge clk);
      gnt = (c == gd); rvalid = ld && (c == gd + rd);
      #1;
      st = b64 ? stall64 : stall32;
      if (c <= gd) begin
        chk({nm, "_req"}, b64 ? req64 : req32, 1'b1);
        chk({nm, "_addr"}, b64 ? addr64 : {32'h0, addr32}, addr);
      end
      if (c == 0 && !ld) begin
        chk({nm, "_wstrb"}, b64 ? strb64 : {4'h0, strb32}, exp_strb);
        chk({nm, "_wdata"}, b64 ? wdata64 : {32'h0, wdata32}, exp_wdata);
      end
      if (st) stalls++;
      else begin
        done = 1;
        e = '{wa: 5'd7, rf_we: ld, is_load: ld, chk_rd: ld, pre: addr, rd: exp_rd};
        if (b64) q64.push_back(e); else q32.push_back(e);
      end
      @(posedge clk);
      #1;
      if (st) begin
        chk({nm, "_stall_wb_valid"}, b64 ? wbv64 : wbv32, 1'b0);
        chk({nm, "_stall_wb_rf_we"}, b64 ? wbwe64 : wbwe32, 1'b0);
      end
    end
    if (!done) chk({nm, "_timeout_stall"}, st, 1'b0);
    chk({nm, "_stall_cycles"}, stalls, exp_stalls);
  endtask

  initial begin
    vec_t vt[10];
    vt[0] = '{1,0,0,3'b000,2'd0,1,5'd1, 0,64'h1234,64'h0,64'h0,64'h0,64'h1234, 0,0,8'h00,64'h0};
    vt[1] = '{1,0,0,3'b000,2'd1,1,5'd2, 0,64'h55,64'hABCD0000,64'h104,64'h0,64'hABCD0000, 0,0,8'h00,64'h0};
    vt[2] = '{1,0,0,3'b000,2'd2,1,5'd3, 0,64'h55,64'hABCD0000,64'h104,64'h0,64'h104, 0,0,8'h00,64'h0};
    vt[3] = '{1,0,1,3'b000,2'd0,0,5'd4, 1,64'h103,64'h0,64'h0,64'hA5,64'h103, 0,1,8'b1000,64'hA5A5A5A5};
    vt[4] = '{1,0,1,3'b001,2'd0,0,5'd4, 1,64'h102,64'h0,64'h0,64'h1234BEEF,64'h102, 0,1,8'b1100,64'hBEEFBEEF};
    vt[5] = '{1,0,1,3'b010,2'd0,0,5'd4, 1,64'h100,64'h0,64'h0,64'hDEADBEEF,64'h100, 0,1,8'b1111,64'hDEADBEEF};
    vt[6] = '{1,0,1,3'b000,2'd0,0,5'd4, 1,64'h101,64'h0,64'h0,64'h77,64'h101, 0,1,8'b0010,64'h77777777};
    vt[7] = '{0,1,0,3'b010,2'd0,1,5'd5, 0,64'h200,64'h0,64'h0,64'h0,64'h200, 0,0,8'h00,64'h0};
    vt[8] = '{1,0,0,3'b000,2'd0,1,5'd31,1,64'h42,64'h0,64'h0,64'h0,64'h42, 0,0,8'h00,64'h0};
    vt[9] = '{1,0,0,3'b000,2'd3,1,5'd6, 0,64'h99,64'h11,64'h22,64'h0,64'h99, 0,0,8'h00,64'h0};

    rstn = 0; v32 = 0; v64 = 0; is_load = 0; dwe = 0; rf_we = 0; gnt = 0; rvalid = 0;
    f3 = 0; wa = 0; sel = 0; alu = 0; imm = 0; pc4 = 0; wd = 0; rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid32", wbv32, 0);
    chk("rst_wb_rf_we32", wbwe32, 0);
    chk("rst_wb_rf_wa32", wbwa32, 0);
    chk("rst_wb_dmem_rd32", wbrd32, 0);
    chk("rst_wb_wd_pre32", wbpre32, 0);
    chk("rst_req32", req32, 0);
    chk("rst_stall32", stall32, 0);
    chk("rst_wb_valid64", wbv64, 0);
    @(negedge clk);
    rstn = 1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v32 = vt[i].vld; v64 = 0; is_load = vt[i].ld; dwe = vt[i].we; f3 = vt[i].f3;
      sel = vt[i].sel; rf_we = vt[i].rfwe; wa = vt[i].wa; gnt = vt[i].g; rvalid = 0;
      alu = vt[i].alu; imm = vt[i].imm; pc4 = vt[i].pc4; wd = vt[i].wd;
      #1;
      chk($sformatf("vec%0d_fwd", i), fwd32, vt[i].fwd);
      chk($sformatf("vec%0d_stall", i), stall32, vt[i].stall);
      chk($sformatf("vec%0d_req", i), req32, vt[i].req);
      if (vt[i].we) begin
        chk($sformatf("vec%0d_wstrb", i), strb32, vt[i].strb);
        chk($sformatf("vec%0d_wdata", i), wdata32, vt[i].wdata);
        chk($sformatf("vec%0d_addr", i), addr32, vt[i].alu);
        chk($sformatf("vec%0d_we", i), we32, 1'b1);
      end
      if (vt[i].vld)
        q32.push_back('{wa: vt[i].wa, rf_we: vt[i].rfwe, is_load: vt[i].ld, chk_rd: 1'b0,
                        pre: vt[i].fwd, rd: 64'h0});
      @(posedge clk);
    end

    mem_seq("lh",  0, 1, 3'b001, 64'h102, 0, 64'h80010000, 2, 3, 64'hFFFF8001, 0, 0, 5);
    mem_seq("lhu", 0, 1, 3'b101, 64'h102, 0, 64'h80010000, 2, 3, 64'h00008001, 0, 0, 5);
    mem_seq("lb",  0, 1, 3'b000, 64'h103, 0, 64'h80112233, 0, 1, 64'hFFFFFF80, 0, 0, 1);
    mem_seq("sw_wait", 0, 0, 3'b010, 64'h200, 64'hCAFEF00D, 0, 2, 0, 0, 8'hF, 64'hCAFEF00D, 2);

    // Reset while a load waits for its response
    @(negedge clk);
    v32 = 1; v64 = 0; is_load = 1; dwe = 0; f3 = 3'b010; alu = 64'h300; rf_we = 1; wa = 5'd8;
    sel = SRC_RF_WD_ALU; gnt = 1; rvalid = 0;
    #1 chk("rsp_rst_req_issue", req32, 1);
    @(posedge clk);
    @(negedge clk);
    gnt = 0;
    #1 chk("rsp_rst_stall_before", stall32, 1);
    chk("rsp_rst_req_in_rsp", req32, 0);
    #1 rstn = 0;
    #1 chk("rsp_rst_stall_after", stall32, 0);
    chk("rsp_rst_req_after", req32, 0);
    @(negedge clk);
    rstn = 1; v32 = 0; rvalid = 1; rdata = 64'h12345678;
    #1 chk("late_rvalid_stall", stall32, 0);
    @(posedge clk);
    #1 chk("late_rvalid_wb_valid", wbv32, 0);
    @(negedge clk);
    rvalid = 0;

`ifdef RV_MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    v32 = 1; v64 = 0; is_load = 1; dwe = 0; f3 = 3'b010; alu = 64'h302; rf_we = 1; wa = 5'd9;
    sel = SRC_RF_WD_ALU; gnt = 1;
    #1 chk("misal_req", req32, 0);
    chk("misal_stall", stall32, 0);
    q32.push_back('{wa: 5'd9, rf_we: 1'b0, is_load: 1'b1, chk_rd: 1'b0, pre: 64'h302, rd: 64'h0});
    @(posedge clk);
    #1 chk("misal_flag", misal32, 1);
    @(negedge clk);
    v32 = 0; gnt = 0;
    @(posedge clk);
    #1 chk("misal_flag_clear", misal32, 0);
`else
    mem_seq("lw_wrap", 0, 1, 3'b010, 64'h302, 0, 64'h11223344, 0, 1, 64'h33441122, 0, 0, 1);
    mem_seq("sh_wrap", 0, 0, 3'b001, 64'h103, 64'hBEEF, 0, 0, 0, 0, 8'b1001, 64'hEFBEEFBE, 0);
`endif

    mem_seq("sd64", 1, 0, 3'b011, 64'h8, 64'h0123456789ABCDEF, 0, 0, 0, 0, 8'hFF,
            64'h0123456789ABCDEF, 0);
    mem_seq("sb64", 1, 0, 3'b000, 64'h6, 64'h5A, 0, 0, 0, 0, 8'h40, 64'h5A5A5A5A5A5A5A5A, 0);
    mem_seq("ld64", 1, 1, 3'b011, 64'h8, 0, 64'hFEDCBA9876543210, 0, 1,
            64'hFEDCBA9876543210, 0, 0, 1);
    mem_seq("lw64", 1, 1, 3'b010, 64'hC, 0, 64'h8000000000000000, 1, 1,
            64'hFFFFFFFF80000000, 0, 0, 2);
    mem_seq("lwu64", 1, 1, 3'b110, 64'hC, 0, 64'h8000000000000000, 0, 2,
            64'h0000000080000000, 0, 0, 2);

    @(negedge clk);
    v32 = 0; v64 = 0; gnt = 0; rvalid = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("sb32_drained", q32.size(), 0);
    chk("sb64_drained", q64.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation reached %0t without finishing", $time);
    $fatal(1);
  end

endmodule
